// File: rtl/network_rx_port_select_pkg.sv
// Shared types for the management-network RX port selector: the RX bus word
// layout and the selector FSM encoding.
package EthernetBus;

    typedef struct packed {
        logic       start;
        logic       data_valid;
        logic [7:0] data;
        logic       commit;
        logic       drop;
    } EthernetRxBus;

endpackage

package NetworkRxSelectPkg;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_ACTIVE = 2'd1,
        SEL_DRAIN  = 2'd2
    } sel_state_t;

    function automatic int port_bits(input int num_ports);
        return (num_ports > 2) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/network_rx_port_select_qualifier.sv
// Per-port link holdoff qualifier and open-frame tracker.
module rx_link_qualifier #(
    parameter int HOLDOFF_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic link_up,
    input  logic rx_start,
    input  logic rx_end,
    output logic qual,
    output logic in_frame
);
    localparam int CW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CW-1:0] HOLD = CW'(HOLDOFF_CYCLES);

    logic [CW-1:0] cnt_r;
    logic          in_frame_r;

    // Saturating holdoff counter, cleared whenever the link is down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!link_up) begin
            cnt_r <= '0;
        end else if (cnt_r != HOLD) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Open-frame flag; an end in the same word as a start wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_r <= 1'b0;
        end else if (rx_end) begin
            in_frame_r <= 1'b0;
        end else if (rx_start) begin
            in_frame_r <= 1'b1;
        end else begin
            in_frame_r <= in_frame_r;
        end
    end

    // Loss is not held off: qual follows link_up down in the same cycle
    assign qual     = link_up & (cnt_r == HOLD);
    assign in_frame = in_frame_r;

endmodule

// File: rtl/network_rx_port_select.sv
// Fixed-priority, link-qualified RX port selector that only changes port on
// frame boundaries. Optional perf counters: NETWORK_RX_PORT_SELECT_PERF_EN.
module network_rx_port_select
    import EthernetBus::*;
    import NetworkRxSelectPkg::*;
#(
    parameter  int NUM_PORTS      = 2,
    parameter  int HOLDOFF_CYCLES = 1024,
    localparam int PORT_BITS      = port_bits(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] link_up,
    input  EthernetRxBus         rx_bus [NUM_PORTS],
    output logic                 eth_link_up,
    output EthernetRxBus         eth_rx_bus,
    output logic [PORT_BITS-1:0] active_port,
    output logic [31:0]          perf_switches,
    output logic [31:0]          perf_truncated
);
    logic [NUM_PORTS-1:0] qual_s, in_frame_s, inf_next_s;
    logic                 any_s;
    logic [PORT_BITS-1:0] best_s, port_s, port_r;
    sel_state_t           state_s, state_r;
    logic                 skip_s, skip_r, out_open_r, link_r;
    logic                 sw_inc_s, tr_inc_s, cur_end_s;
    EthernetRxBus         cur_s, fwd_s, out_s, out_r;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        rx_link_qualifier #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_qual (
            .clk      (clk),
            .rst_n    (rst_n),
            .link_up  (link_up[g]),
            .rx_start (rx_bus[g].start),
            .rx_end   (rx_bus[g].commit | rx_bus[g].drop),
            .qual     (qual_s[g]),
            .in_frame (in_frame_s[g])
        );
        // Frame still open after this word, counting a start seen this cycle
        assign inf_next_s[g] = ~(rx_bus[g].commit | rx_bus[g].drop)
                               & (rx_bus[g].start | in_frame_s[g]);
    end

    // Lowest qualified index wins
    always_comb begin
        best_s = '0;
        any_s  = |qual_s;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            best_s = qual_s[i] ? PORT_BITS'(i) : best_s;
        end
    end

    // Selection FSM next state and next output word
    always_comb begin
        state_s   = state_r;
        port_s    = port_r;
        skip_s    = skip_r;
        sw_inc_s  = 1'b0;
        tr_inc_s  = 1'b0;
        out_s     = '0;
        cur_s     = rx_bus[port_r];
        cur_end_s = cur_s.commit | cur_s.drop;
        fwd_s     = skip_r ? EthernetRxBus'('0) : cur_s;
        case (state_r)
            SEL_NONE: begin
                if (any_s) begin
                    state_s  = SEL_ACTIVE;
                    port_s   = best_s;
                    skip_s   = inf_next_s[best_s];
                    sw_inc_s = 1'b1;
                end else begin
                    state_s  = SEL_NONE;
                end
            end
            SEL_ACTIVE, SEL_DRAIN: begin
                if (!qual_s[port_r]) begin
                    out_s.drop = out_open_r;
                    tr_inc_s   = out_open_r;
                    if (any_s) begin
                        state_s  = SEL_ACTIVE;
                        port_s   = best_s;
                        skip_s   = inf_next_s[best_s];
                        sw_inc_s = 1'b1;
                    end else begin
                        state_s  = SEL_NONE;
                        skip_s   = 1'b0;
                    end
                end else if (best_s == port_r) begin
                    out_s   = fwd_s;
                    state_s = SEL_ACTIVE;
                    skip_s  = skip_r & ~cur_end_s;
                end else if (inf_next_s[port_r] & ~skip_r) begin
                    // Output is carrying a frame from this port: let it finish
                    out_s   = fwd_s;
                    state_s = SEL_DRAIN;
                end else begin
                    out_s    = fwd_s;
                    state_s  = SEL_ACTIVE;
                    port_s   = best_s;
                    skip_s   = inf_next_s[best_s];
                    sw_inc_s = 1'b1;
                end
            end
            default: begin
                state_s = SEL_NONE;
                skip_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= SEL_NONE;
            port_r     <= '0;
            skip_r     <= 1'b0;
            out_r      <= '0;
            out_open_r <= 1'b0;
            link_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            port_r     <= port_s;
            skip_r     <= skip_s;
            out_r      <= out_s;
            out_open_r <= (out_s.commit | out_s.drop) ? 1'b0 : (out_s.start | out_open_r);
            link_r     <= any_s;
        end
    end

    assign eth_link_up = link_r;
    assign eth_rx_bus  = out_r;
    assign active_port = port_r;

`ifdef NETWORK_RX_PORT_SELECT_PERF_EN
    logic [31:0] sw_cnt_r, tr_cnt_r;

    // Free-running wrap-around event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_cnt_r <= 32'd0;
            tr_cnt_r <= 32'd0;
        end else begin
            sw_cnt_r <= sw_cnt_r + {31'd0, sw_inc_s};
            tr_cnt_r <= tr_cnt_r + {31'd0, tr_inc_s};
        end
    end

    assign perf_switches  = sw_cnt_r;
    assign perf_truncated = tr_cnt_r;
`else
    logic perf_unused_s;
    assign perf_unused_s  = sw_inc_s ^ tr_inc_s;
    assign perf_switches  = 32'd0;
    assign perf_truncated = 32'd0;
`endif

endmodule

// File: tb/tb_network_rx_port_select.sv
// Self-checking bench: a 2-port/1024-holdoff instance for directed scenarios
// and a 4-port/4-holdoff instance for table and random traffic.
module tb_network_rx_port_select;
    import EthernetBus::*;

`ifdef NETWORK_RX_PORT_SELECT_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif
    localparam int HA = 1024;
    localparam int HB = 4;

    typedef struct packed {
        logic [3:0][10:0] cnt;
        logic [3:0]       open_in;
        logic             has_sel;
        logic [1:0]       port;
        logic             hide;
        logic             out_open;
        logic [31:0]      nsw;
        logic [31:0]      ntr;
        EthernetRxBus     out;
        logic             lu;
    } mdl_t;

    typedef struct packed {
        logic [3:0] link;
        logic       exp_lu;
        logic [1:0] exp_ap;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;
    logic [1:0] lu_a;
    logic [3:0] lu_b;
    EthernetRxBus [3:0] pb_a, pb_b;
    EthernetRxBus bus_a [2];
    EthernetRxBus bus_b [4];
    logic elu_a, elu_b;
    EthernetRxBus ebus_a, ebus_b;
    logic [0:0] ap_a;
    logic [1:0] ap_b;
    logic [31:0] sw_a, tr_a, sw_b, tr_b;

    assign bus_a[0] = pb_a[0];
    assign bus_a[1] = pb_a[1];
    assign bus_b[0] = pb_b[0];
    assign bus_b[1] = pb_b[1];
    assign bus_b[2] = pb_b[2];
    assign bus_b[3] = pb_b[3];

    network_rx_port_select #(.NUM_PORTS(2), .HOLDOFF_CYCLES(HA)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .link_up(lu_a), .rx_bus(bus_a),
        .eth_link_up(elu_a), .eth_rx_bus(ebus_a), .active_port(ap_a),
        .perf_switches(sw_a), .perf_truncated(tr_a));

    network_rx_port_select #(.NUM_PORTS(4), .HOLDOFF_CYCLES(HB)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .link_up(lu_b), .rx_bus(bus_b),
        .eth_link_up(elu_b), .eth_rx_bus(ebus_b), .active_port(ap_b),
        .perf_switches(sw_b), .perf_truncated(tr_b));

    int n_total = 0;
    int n_pass  = 0;
    mdl_t ma, mb;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic EthernetRxBus wd(input logic s, input logic [7:0] d, input logic c, input logic dr);
        EthernetRxBus w;
        w.start = s; w.data_valid = 1'b1; w.data = d; w.commit = c; w.drop = dr;
        return w;
    endfunction

    // Reference: one clock of the selector, written from the selection rules
    function automatic mdl_t mstep(input mdl_t s, input int n, input int h,
                                   input logic [3:0] link, input EthernetRxBus [3:0] b);
        mdl_t t;
        logic [3:0] q, opn;
        int best, p;
        t = s; q = '0; opn = '0; best = -1;
        for (int i = 0; i < n; i++) begin
            q[i] = link[i] && (int'(s.cnt[i]) >= h);
            opn[i] = (b[i].commit || b[i].drop) ? 1'b0 : (b[i].start || s.open_in[i]);
            t.cnt[i] = !link[i] ? 11'd0 : ((int'(s.cnt[i]) >= h) ? s.cnt[i] : s.cnt[i] + 11'd1);
            t.open_in[i] = opn[i];
        end
        for (int i = n - 1; i >= 0; i--) if (q[i]) best = i;
        t.lu = (best >= 0);
        t.out = '0;
        p = int'(s.port);
        if (s.has_sel && q[p]) begin
            t.out = s.hide ? EthernetRxBus'('0) : b[p];
            if (best == p) begin
                t.hide = s.hide && !(b[p].commit || b[p].drop);
            end else if (!(opn[p] && !s.hide)) begin
                t.port = best[1:0]; t.hide = opn[best]; t.nsw = s.nsw + 32'd1;
            end
        end else begin
            if (s.has_sel && s.out_open) begin
                t.out.drop = 1'b1;
                t.ntr = s.ntr + 32'd1;
            end
            if (best >= 0) begin
                t.has_sel = 1'b1; t.port = best[1:0]; t.hide = opn[best]; t.nsw = s.nsw + 32'd1;
            end else begin
                t.has_sel = 1'b0; t.hide = 1'b0;
            end
        end
        t.out_open = (t.out.commit || t.out.drop) ? 1'b0 : (t.out.start || s.out_open);
        return t;
    endfunction

    task automatic tick();
        if (!rst_a_n) ma = '0; else ma = mstep(ma, 2, HA, {2'b00, lu_a}, pb_a);
        if (!rst_b_n) mb = '0; else mb = mstep(mb, 4, HB, lu_b, pb_b);
        @(posedge clk);
        #1;
        chk("cyc_a_out", {elu_a, (ma.lu ? {1'b0, ap_a} : 2'b00), ebus_a},
                         {ma.lu, (ma.lu ? ma.port : 2'b00), ma.out});
        chk("cyc_a_perf", {sw_a, tr_a}, PERF_EN ? {ma.nsw, ma.ntr} : 64'd0);
        chk("cyc_b_out", {elu_b, (mb.lu ? ap_b : 2'b00), ebus_b},
                         {mb.lu, (mb.lu ? mb.port : 2'b00), mb.out});
        chk("cyc_b_perf", {sw_b, tr_b}, PERF_EN ? {mb.nsw, mb.ntr} : 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        int glen [4];
        int len;
        logic dr;
        EthernetRxBus w;

        tbl[0] = '{4'b1100, 1'b1, 2'd2};
        tbl[1] = '{4'b0000, 1'b0, 2'd0};
        tbl[2] = '{4'b1000, 1'b1, 2'd3};
        tbl[3] = '{4'b0110, 1'b1, 2'd1};
        tbl[4] = '{4'b0111, 1'b1, 2'd0};
        tbl[5] = '{4'b0101, 1'b1, 2'd0};
        tbl[6] = '{4'b1010, 1'b1, 2'd1};
        tbl[7] = '{4'b0100, 1'b1, 2'd2};

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        lu_a = '0; lu_b = '0; pb_a = '0; pb_b = '0;
        ma = '0; mb = '0;
        tick(); tick();
        chk("reset_a", {elu_a, ap_a, ebus_a, sw_a, tr_a}, 96'd0);
        chk("reset_b", {elu_b, ap_b, ebus_b, sw_b, tr_b}, 96'd0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // Port 1 alone: qualifies after the holdoff, frames pass one cycle later
        lu_a = 2'b10;
        repeat (HA) tick();
        chk("qual_before", elu_a, 96'd0);
        tick();
        chk("qual_after", {elu_a, ap_a}, 96'b11);
        for (int k = 0; k < 3; k++) begin
            w = wd(k == 0, 8'(8'h11 * (k + 1)), k == 2, 1'b0);
            pb_a[1] = w;
            tick();
            chk("fwd_p1", ebus_a, 96'(w));
        end
        pb_a[1] = '0;

        // Port 0 qualifies mid-frame on port 1: drain, then move to port 0
        pb_a[1] = wd(1'b1, 8'h40, 1'b0, 1'b0);
        tick();
        lu_a = 2'b11;
        for (int k = 0; k < HA + 2; k++) begin
            pb_a[1] = wd(1'b0, 8'(k), 1'b0, 1'b0);
            tick();
        end
        w = wd(1'b0, 8'hEE, 1'b1, 1'b0);
        pb_a[1] = w;
        tick();
        chk("drain_commit", ebus_a, 96'(w));
        pb_a[1] = '0;
        w = wd(1'b1, 8'hA5, 1'b0, 1'b0);
        pb_a[0] = w;
        tick();
        chk("p0_after_drain", {ap_a, ebus_a}, {1'b0, w});
        chk("perf_sw2", sw_a, PERF_EN ? 96'd2 : 96'd0);
        pb_a[0] = wd(1'b0, 8'hA6, 1'b1, 1'b0);
        tick();
        pb_a[0] = '0;
        tick();

        // Link 0 lost in word 3 of a 10-word frame
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) lu_a[0] = 1'b0;
            pb_a[0] = wd(k == 1, 8'(k), k == 10, 1'b0);
            tick();
            if (k == 3) begin
                chk("trunc_drop", ebus_a, 96'h001);
                chk("takeover_p1", {elu_a, ap_a}, 96'b11);
            end
            if (k == 4) chk("post_drop_idle", ebus_a, 96'd0);
        end
        pb_a[0] = '0;
        chk("perf_trunc", tr_a, PERF_EN ? 96'd1 : 96'd0);

        // Switch onto port 1 while it is mid-frame
        lu_a[0] = 1'b1;
        repeat (HA + 1) tick();
        chk("p0_back", ap_a, 96'd0);
        pb_a[1] = wd(1'b1, 8'h50, 1'b0, 1'b0); tick();
        pb_a[1] = wd(1'b0, 8'h51, 1'b0, 1'b0); tick();
        lu_a[0] = 1'b0;
        pb_a[1] = wd(1'b0, 8'h52, 1'b0, 1'b0); tick();
        chk("switch_mid", {elu_a, ap_a, ebus_a}, {2'b11, 12'h000});
        pb_a[1] = wd(1'b0, 8'h53, 1'b0, 1'b0); tick();
        chk("skip_word", ebus_a, 96'd0);
        pb_a[1] = wd(1'b0, 8'h54, 1'b1, 1'b0); tick();
        chk("skip_commit", ebus_a, 96'd0);
        w = wd(1'b1, 8'h60, 1'b0, 1'b0);
        pb_a[1] = w; tick();
        chk("next_start_fwd", ebus_a, 96'(w));
        pb_a[1] = wd(1'b0, 8'h61, 1'b1, 1'b0); tick();
        pb_a[1] = '0;

        // Link glitch restarts the holdoff
        lu_a[0] = 1'b1;
        repeat (HA - 1) tick();
        lu_a[0] = 1'b0;
        tick();
        lu_a[0] = 1'b1;
        repeat (HA) tick();
        chk("glitch_hold", ap_a, 96'd1);
        tick();
        chk("glitch_sel", ap_a, 96'd0);

        // 4-port link pattern table, no traffic
        for (int v = 0; v < 8; v++) begin
            lu_b = tbl[v].link;
            repeat (HB + 3) tick();
            chk("tbl_link", elu_b, 96'(tbl[v].exp_lu));
            if (tbl[v].exp_lu) chk("tbl_port", ap_b, 96'(tbl[v].exp_ap));
        end

        // Links 3 and 2 up, then reset in the middle of a port-2 frame
        lu_b = 4'b1100;
        repeat (HB + 3) tick();
        chk("four_port_sel", ap_b, 96'd2);
        pb_b[2] = wd(1'b1, 8'h70, 1'b0, 1'b0); tick();
        w = wd(1'b0, 8'h71, 1'b0, 1'b0);
        pb_b[2] = w; tick();
        chk("four_port_fwd", ebus_b, 96'(w));
        rst_b_n = 1'b0;
        #1;
        chk("rst_async", {elu_b, ap_b, ebus_b, sw_b, tr_b}, 96'd0);
        mb = '0;
        pb_b = '0;
        tick();
        rst_b_n = 1'b1;

        // Random traffic and link flaps on the 4-port instance
        lu_b = 4'b1111;
        for (int i = 0; i < 4; i++) glen[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 39) == 0) lu_b[i] = ~lu_b[i];
                dr = ($urandom_range(0, 7) == 0);
                if (!lu_b[i]) begin
                    glen[i] = 0;
                    pb_b[i] = '0;
                end else if (glen[i] == 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        len = int'($urandom_range(1, 6));
                        pb_b[i] = wd(1'b1, 8'($urandom), (len == 1) && !dr, (len == 1) && dr);
                        glen[i] = len - 1;
                    end else begin
                        pb_b[i] = '0;
                    end
                end else begin
                    pb_b[i] = wd(1'b0, 8'($urandom), (glen[i] == 1) && !dr, (glen[i] == 1) && dr);
                    glen[i] = glen[i] - 1;
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
